// File: rtl/stopwatch_cnt_if.sv
// ---------------------------------------------------------------------------
// stopwatch_cnt_if
// Bundles the front-panel controls and the display-side results of the
// stopwatch counter so they can be passed as one port.
//
// Signals (named from the counter's point of view):
//   i_btnSs    start/stop button level (debounced)
//   i_btnLap   lap button level (debounced)
//   i_clr      synchronous clear level
//   i_down     count direction, 1 = down
//   i_load     preload strobe, honoured only while idle
//   i_loadVal  preload value
//   o_val      current count
//   o_lapVal   captured lap value
//   o_lapVld   o_lapVal holds a valid capture
//   o_run      counter is running
//   o_tick     one-cycle pulse when o_val shows an updated value
//   o_done     one-cycle pulse when o_val shows a terminal update
//
// Modports:
//   master  drives the controls, observes the results (panel / bench side)
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface stopwatch_cnt_if #(
    parameter int VAL_W = 16
);

    logic             i_btnSs;
    logic             i_btnLap;
    logic             i_clr;
    logic             i_down;
    logic             i_load;
    logic [VAL_W-1:0] i_loadVal;
    logic [VAL_W-1:0] o_val;
    logic [VAL_W-1:0] o_lapVal;
    logic             o_lapVld;
    logic             o_run;
    logic             o_tick;
    logic             o_done;

    modport master (
        output i_btnSs, i_btnLap, i_clr, i_down, i_load, i_loadVal,
        input  o_val, o_lapVal, o_lapVld, o_run, o_tick, o_done
    );

    modport slave (
        input  i_btnSs, i_btnLap, i_clr, i_down, i_load, i_loadVal,
        output o_val, o_lapVal, o_lapVld, o_run, o_tick, o_done
    );

endinterface

// File: rtl/stopwatch_cnt.sv
// ---------------------------------------------------------------------------
// stopwatch_cnt
// Start/stop event counter with an internal prescaler. While running, the
// count moves up or down by one every TICK_DIV clocks. Supports lap capture,
// preload while idle, and either wrap-around or saturate-and-stop at the
// terminal values 0 / MAX_VAL. Every output comes straight from a register.
//
// Parameters:
//   TICK_DIV  clocks per count tick (>= 2)
//   VAL_W     width of the count, lap value and preload value
//   MAX_VAL   terminal value, must fit in VAL_W bits
//   SAT       0: wrap at terminal, 1: hold at terminal and stop
//
// Ports:
//   i_clk     clock, rising edge
//   i_rstN    synchronous active-low reset
//   bus       stopwatch_cnt_if slave modport (controls in, results out)
// ---------------------------------------------------------------------------
module stopwatch_cnt #(
    parameter int TICK_DIV = 100_000_000,
    parameter int VAL_W    = 16,
    parameter int MAX_VAL  = 65535,
    parameter int SAT      = 0
) (
    input  logic            i_clk,
    input  logic            i_rstN,
    stopwatch_cnt_if.slave  bus
);

    localparam int               PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [VAL_W-1:0] MAX_V   = VAL_W'(MAX_VAL);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [VAL_W-1:0] r_val;
    logic [VAL_W-1:0] r_lapVal;
    logic             r_lapVld;
    logic             r_tick;
    logic             r_done;
    logic [PS_W-1:0]  r_prescale;
    logic             r_ssPrev;
    logic             r_lapPrev;

    state_t           w_stateNext;
    logic [VAL_W-1:0] w_valNext;
    logic [VAL_W-1:0] w_lapValNext;
    logic             w_lapVldNext;
    logic             w_tickNext;
    logic             w_doneNext;
    logic [PS_W-1:0]  w_prescaleNext;

    logic             w_ssRise;
    logic             w_lapRise;
    logic             w_tickNow;
    logic             w_terminal;

    // Button edges come from comparing the live level against last cycle's
    // level. A tick is due on the edge where the prescaler sits at its last
    // value while running. "Terminal" means the value a tick starts from is
    // the end of the range in the current direction.
    assign w_ssRise   = bus.i_btnSs & ~r_ssPrev;
    assign w_lapRise  = bus.i_btnLap & ~r_lapPrev;
    assign w_tickNow  = (r_state == RUN) && (r_prescale == PS_LAST);
    assign w_terminal = bus.i_down ? (r_val == '0) : (r_val == MAX_V);

    // Next-state and next-output logic. Clear beats everything except reset;
    // load only matters while idle, and a start press on the same edge still
    // starts counting from the loaded value. In RUN the tick update, lap
    // capture (which sees the pre-update count) and the stop press are all
    // applied together; a saturating terminal tick also forces IDLE.
    always_comb begin
        w_stateNext    = r_state;
        w_valNext      = r_val;
        w_lapValNext   = r_lapVal;
        w_lapVldNext   = r_lapVld;
        w_tickNext     = 1'b0;
        w_doneNext     = 1'b0;
        w_prescaleNext = r_prescale;

        if (bus.i_clr) begin
            w_stateNext    = IDLE;
            w_valNext      = '0;
            w_lapValNext   = '0;
            w_lapVldNext   = 1'b0;
            w_prescaleNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_load) begin
                        w_valNext = (bus.i_loadVal > MAX_V) ? MAX_V : bus.i_loadVal;
                    end
                    if (w_lapRise) begin
                        w_lapVldNext = 1'b0;
                    end
                    if (w_ssRise) begin
                        w_stateNext = RUN;
                    end
                end
                RUN: begin
                    w_prescaleNext = (r_prescale == PS_LAST) ? '0 : r_prescale + 1'b1;
                    if (w_lapRise) begin
                        w_lapValNext = r_val;
                        w_lapVldNext = 1'b1;
                    end
                    if (w_ssRise) begin
                        w_stateNext = IDLE;
                    end
                    if (w_tickNow) begin
                        w_tickNext = 1'b1;
                        w_doneNext = w_terminal;
                        if (w_terminal && (SAT != 0)) begin
                            w_stateNext = IDLE;
                        end else if (w_terminal) begin
                            w_valNext = bus.i_down ? MAX_V : '0;
                        end else begin
                            w_valNext = bus.i_down ? (r_val - 1'b1) : (r_val + 1'b1);
                        end
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // State and output registers. Button history resets to 1 so a button
    // held down through reset is not mistaken for a fresh press; it keeps
    // tracking the buttons during clear.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_state    <= IDLE;
            r_val      <= '0;
            r_lapVal   <= '0;
            r_lapVld   <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_prescale <= '0;
            r_ssPrev   <= 1'b1;
            r_lapPrev  <= 1'b1;
        end else begin
            r_state    <= w_stateNext;
            r_val      <= w_valNext;
            r_lapVal   <= w_lapValNext;
            r_lapVld   <= w_lapVldNext;
            r_tick     <= w_tickNext;
            r_done     <= w_doneNext;
            r_prescale <= w_prescaleNext;
            r_ssPrev   <= bus.i_btnSs;
            r_lapPrev  <= bus.i_btnLap;
        end
    end

    assign bus.o_val    = r_val;
    assign bus.o_lapVal = r_lapVal;
    assign bus.o_lapVld = r_lapVld;
    assign bus.o_run    = (r_state == RUN);
    assign bus.o_tick   = r_tick;
    assign bus.o_done   = r_done;

endmodule

// File: tb/tb_stopwatch_cnt.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_cnt
// Drives a wrapping and a saturating stopwatch_cnt with identical directed
// stimulus. A per-edge behavioural model of both is checked against the DUT
// outputs on every falling edge, and literal expectations at key points
// anchor the model.
// ---------------------------------------------------------------------------
module tb_stopwatch_cnt;

    localparam int TICK_DIV = 4;
    localparam int VAL_W    = 4;
    localparam int MAX_VAL  = 9;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             btnSs = 1'b1;
    logic             btnLap = 1'b0;
    logic             clr = 1'b0;
    logic             down = 1'b0;
    logic             load = 1'b0;
    logic [VAL_W-1:0] loadVal = '0;

    int compared   = 0;
    int mismatched = 0;
    bit cmpEn      = 1'b0;

    // Model state, index 0 = wrapping instance, index 1 = saturating one
    int mVal[2];
    int mLap[2];
    int mVld[2];
    int mRun[2];
    int mTick[2];
    int mDone[2];
    int mPhase[2];
    int mSsPrev  = 1;
    int mLapPrev = 1;

    logic [VAL_W-1:0] dutVal[2];
    logic [VAL_W-1:0] dutLap[2];
    logic             dutVld[2];
    logic             dutRun[2];
    logic             dutTick[2];
    logic             dutDone[2];

    always #5 clk = ~clk;

    stopwatch_cnt_if #(.VAL_W(VAL_W)) busWrap ();
    stopwatch_cnt_if #(.VAL_W(VAL_W)) busSat ();

    assign busWrap.i_btnSs   = btnSs;
    assign busWrap.i_btnLap  = btnLap;
    assign busWrap.i_clr     = clr;
    assign busWrap.i_down    = down;
    assign busWrap.i_load    = load;
    assign busWrap.i_loadVal = loadVal;
    assign busSat.i_btnSs    = btnSs;
    assign busSat.i_btnLap   = btnLap;
    assign busSat.i_clr      = clr;
    assign busSat.i_down     = down;
    assign busSat.i_load     = load;
    assign busSat.i_loadVal  = loadVal;

    assign dutVal[0]  = busWrap.o_val;
    assign dutLap[0]  = busWrap.o_lapVal;
    assign dutVld[0]  = busWrap.o_lapVld;
    assign dutRun[0]  = busWrap.o_run;
    assign dutTick[0] = busWrap.o_tick;
    assign dutDone[0] = busWrap.o_done;
    assign dutVal[1]  = busSat.o_val;
    assign dutLap[1]  = busSat.o_lapVal;
    assign dutVld[1]  = busSat.o_lapVld;
    assign dutRun[1]  = busSat.o_run;
    assign dutTick[1] = busSat.o_tick;
    assign dutDone[1] = busSat.o_done;

    stopwatch_cnt #(
        .TICK_DIV (TICK_DIV),
        .VAL_W    (VAL_W),
        .MAX_VAL  (MAX_VAL),
        .SAT      (0)
    ) dutWrap (
        .i_clk  (clk),
        .i_rstN (rstN),
        .bus    (busWrap)
    );

    stopwatch_cnt #(
        .TICK_DIV (TICK_DIV),
        .VAL_W    (VAL_W),
        .MAX_VAL  (MAX_VAL),
        .SAT      (1)
    ) dutSat (
        .i_clk  (clk),
        .i_rstN (rstN),
        .bus    (busSat)
    );

    // One comparison: bump the counters and report a failure on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Set every control input, then let n falling edges pass.
    task automatic applyStimulus(input bit ss, input bit lap, input bit c,
                                 input bit ld, input int lv, input int n);
        btnSs   = ss;
        btnLap  = lap;
        clr     = c;
        load    = ld;
        loadVal = VAL_W'(lv);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: one step per rising edge, in plain arithmetic.
    // mPhase counts running clocks modulo TICK_DIV; the count lives in the
    // range 0..MAX_VAL and moves by modular arithmetic unless saturating.
    always @(posedge clk) begin
        int  oldVal;
        int  ssRise;
        int  lapRise;
        int  term;
        int  stopSat;
        ssRise  = (btnSs === 1'b1 && mSsPrev == 0) ? 1 : 0;
        lapRise = (btnLap === 1'b1 && mLapPrev == 0) ? 1 : 0;
        for (int s = 0; s < 2; s++) begin
            oldVal  = mVal[s];
            stopSat = 0;
            mTick[s] = 0;
            mDone[s] = 0;
            if (rstN !== 1'b1) begin
                mVal[s] = 0; mLap[s] = 0; mVld[s] = 0; mRun[s] = 0; mPhase[s] = 0;
            end else if (clr === 1'b1) begin
                mVal[s] = 0; mLap[s] = 0; mVld[s] = 0; mRun[s] = 0; mPhase[s] = 0;
            end else begin
                if (mRun[s] == 0 && load === 1'b1) begin
                    mVal[s] = (int'(loadVal) > MAX_VAL) ? MAX_VAL : int'(loadVal);
                end
                if (mRun[s] == 1) begin
                    mPhase[s] = (mPhase[s] + 1) % TICK_DIV;
                    if (mPhase[s] == 0) begin
                        term = (down === 1'b1) ? (oldVal == 0) : (oldVal == MAX_VAL);
                        mTick[s] = 1;
                        mDone[s] = term;
                        if (term != 0 && s == 1) begin
                            stopSat = 1;
                        end else if (down === 1'b1) begin
                            mVal[s] = (oldVal + MAX_VAL) % (MAX_VAL + 1);
                        end else begin
                            mVal[s] = (oldVal + 1) % (MAX_VAL + 1);
                        end
                    end
                end
                if (lapRise != 0) begin
                    if (mRun[s] == 1) begin
                        mLap[s] = oldVal;
                        mVld[s] = 1;
                    end else begin
                        mVld[s] = 0;
                    end
                end
                mRun[s] = (mRun[s] ^ ssRise) & ~stopSat;
            end
        end
        if (rstN !== 1'b1) begin
            mSsPrev  = 1;
            mLapPrev = 1;
        end else begin
            mSsPrev  = (btnSs === 1'b1) ? 1 : 0;
            mLapPrev = (btnLap === 1'b1) ? 1 : 0;
        end
    end

    // Every falling edge once reset has been applied: all outputs of both
    // instances against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            for (int s = 0; s < 2; s++) begin
                checkOutput($sformatf("model val[%0d]", s),  32'(dutVal[s]),  mVal[s]);
                checkOutput($sformatf("model lap[%0d]", s),  32'(dutLap[s]),  mLap[s]);
                checkOutput($sformatf("model vld[%0d]", s),  32'(dutVld[s]),  mVld[s]);
                checkOutput($sformatf("model run[%0d]", s),  32'(dutRun[s]),  mRun[s]);
                checkOutput($sformatf("model tick[%0d]", s), 32'(dutTick[s]), mTick[s]);
                checkOutput($sformatf("model done[%0d]", s), 32'(dutDone[s]), mDone[s]);
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        // Start/stop held high through reset must not register as a press
        rstN = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 2);
        rstN  = 1'b1;
        cmpEn = 1'b1;
        checkOutput("rst val", 32'(dutVal[0]), 0);
        checkOutput("rst run", 32'(dutRun[0]), 0);
        checkOutput("rst lapVld", 32'(dutVld[1]), 0);
        applyStimulus(1, 0, 0, 0, 0, 10);
        checkOutput("held run", 32'(dutRun[0]), 0);
        checkOutput("held val", 32'(dutVal[0]), 0);
        checkOutput("held tick", 32'(dutTick[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("press run", 32'(dutRun[0]), 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("clr run", 32'(dutRun[0]), 0);

        // Pause/resume keeps the prescaler phase
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 3);
        checkOutput("s2 no tick yet", 32'(dutTick[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("s2 tick1", 32'(dutTick[0]), 1);
        checkOutput("s2 val1", 32'(dutVal[0]), 1);
        applyStimulus(0, 0, 0, 0, 0, 4);
        checkOutput("s2 tick2", 32'(dutTick[0]), 1);
        checkOutput("s2 val2", 32'(dutVal[0]), 2);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("s2 stopped", 32'(dutRun[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 20);
        checkOutput("s2 held val", 32'(dutVal[0]), 2);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 2);
        checkOutput("s2 resume early", 32'(dutTick[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("s2 resume tick", 32'(dutTick[0]), 1);
        checkOutput("s2 resume val", 32'(dutVal[0]), 3);
        applyStimulus(0, 0, 1, 0, 0, 1);

        // Terminal up-count: wrap vs saturate
        applyStimulus(0, 0, 0, 1, 8, 1);
        checkOutput("s3 load8", 32'(dutVal[1]), 8);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 4);
        checkOutput("s3 val9", 32'(dutVal[0]), 9);
        checkOutput("s3 no done", 32'(dutDone[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 4);
        checkOutput("s3 wrap val", 32'(dutVal[0]), 0);
        checkOutput("s3 wrap done", 32'(dutDone[0]), 1);
        checkOutput("s3 wrap run", 32'(dutRun[0]), 1);
        checkOutput("s3 sat val", 32'(dutVal[1]), 9);
        checkOutput("s3 sat done", 32'(dutDone[1]), 1);
        checkOutput("s3 sat run", 32'(dutRun[1]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("s3 done once", 32'(dutDone[1]), 0);
        applyStimulus(0, 0, 1, 0, 0, 1);

        // Down-count from a preload, then a clamped preload
        down = 1'b1;
        applyStimulus(0, 0, 0, 1, 3, 1);
        checkOutput("s4 load3", 32'(dutVal[1]), 3);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 4);
        checkOutput("s4 val2", 32'(dutVal[1]), 2);
        applyStimulus(0, 0, 0, 0, 0, 8);
        checkOutput("s4 val0", 32'(dutVal[1]), 0);
        checkOutput("s4 not done", 32'(dutDone[1]), 0);
        applyStimulus(0, 0, 0, 0, 0, 4);
        checkOutput("s4 sat done", 32'(dutDone[1]), 1);
        checkOutput("s4 sat run", 32'(dutRun[1]), 0);
        checkOutput("s4 sat val", 32'(dutVal[1]), 0);
        checkOutput("s4 wrap val", 32'(dutVal[0]), 9);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 12, 1);
        checkOutput("s4 clamp", 32'(dutVal[0]), 9);
        down = 1'b0;
        applyStimulus(0, 0, 1, 0, 0, 1);

        // Lap on the same edge as a tick, then lap while idle
        applyStimulus(0, 0, 0, 1, 5, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("s5 lapVal", 32'(dutLap[0]), 5);
        checkOutput("s5 lapVld", 32'(dutVld[0]), 1);
        checkOutput("s5 val6", 32'(dutVal[0]), 6);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("s5 stopped", 32'(dutRun[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("s5 idle lapVld", 32'(dutVld[0]), 0);
        checkOutput("s5 idle lapVal", 32'(dutLap[0]), 5);

        // Priority: load ignored in RUN, clear beats start and tick
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 2, 1);
        checkOutput("s6 load ignored", 32'(dutVal[0]), 6);
        checkOutput("s6 still run", 32'(dutRun[0]), 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 0, 1);
        checkOutput("s6 clr val", 32'(dutVal[0]), 0);
        checkOutput("s6 clr run", 32'(dutRun[0]), 0);
        checkOutput("s6 clr tick", 32'(dutTick[0]), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("s6 clr tick2", 32'(dutTick[0]), 0);

        // Reset in the middle of a run with a valid lap
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 4);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("s6 lap pre-rst", 32'(dutLap[0]), 1);
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("s6 rst val", 32'(dutVal[0]), 0);
        checkOutput("s6 rst lap", 32'(dutLap[0]), 0);
        checkOutput("s6 rst vld", 32'(dutVld[0]), 0);
        checkOutput("s6 rst run", 32'(dutRun[0]), 0);
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 2);
        checkOutput("s6 after rst run", 32'(dutRun[1]), 0);

        cmpEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stopwatch_cnt.md
Name: stopwatch_cnt

Overview:
Parametrised start/stop event counter with an internal prescaler. It increments or decrements a VAL_W-bit value once every TICK_DIV clock cycles while running. Buttons are edge-detected internally. It adds lap capture, preload, direction select and a wrap or saturate terminal mode. It sits between the debounced front-panel buttons and the display driver.

Parameters:
TICK_DIV  100_000_000  clock cycles per count tick (>=2)
VAL_W     16           width of VAL, LAP_VAL and LOAD_VAL
MAX_VAL   65535        terminal value; must be < 2**VAL_W
SAT       0            0: wrap at terminal; 1: hold at terminal and stop

Ports:
CLK       in   1      clock, all logic on rising edge
RST_N     in   1      synchronous, active-low reset
BTN_SS    in   1      start/stop button, level; rising edge toggles run state
BTN_LAP   in   1      lap button, level; rising edge acts
CLR       in   1      synchronous clear, level
DOWN      in   1      1: count down; 0: count up; sampled on each tick
LOAD      in   1      preload strobe, honoured only while idle
LOAD_VAL  in   VAL_W  preload value
VAL       out  VAL_W  current count
LAP_VAL   out  VAL_W  captured lap value
LAP_VLD   out  1      LAP_VAL holds a valid capture
RUN       out  1      1 while in RUN state
TICK      out  1      one-cycle pulse, high in the cycle VAL shows an updated value
DONE      out  1      one-cycle pulse, high in the cycle VAL shows a terminal update

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - VAL=0, LAP_VAL=0, LAP_VLD=0, RUN=0, TICK=0, DONE=0.
  - Prescaler=0; state IDLE.
  - Both button history registers are set to 1, so a button held through reset does not produce an edge.
- Edge detect: rise = BTN & ~BTN_prev; BTN_prev is registered every cycle.
- States: IDLE, RUN.
  - IDLE -> RUN on BTN_SS rise.
  - RUN -> IDLE on BTN_SS rise, or on a saturating terminal tick (SAT=1).
- Priority per edge: RST_N > CLR > LOAD > BTN_SS rise / tick / lap.
- CLR:
  - VAL=0, prescaler=0, LAP_VAL=0, LAP_VLD=0, state IDLE.
  - TICK and DONE are 0 on the following cycle.
  - BTN_prev registers still update.
- LOAD:
  - In IDLE and not CLR: VAL <= min(LOAD_VAL, MAX_VAL); the prescaler is untouched.
  - Ignored in RUN.
  - A same-cycle BTN_SS rise is still honoured: VAL takes the loaded value, and counting starts from it.
- Prescaler:
  - Counts only in RUN, 0..TICK_DIV-1.
  - At TICK_DIV-1 it returns to 0 and a tick occurs on that edge.
  - Holds its value in IDLE, so pause/resume preserves the fractional period.
  - First tick after a start from prescaler=0 comes TICK_DIV cycles after the start edge registers.
- Tick update (registered, same edge):
  - Up, VAL<MAX_VAL: VAL+1.
  - Up, VAL==MAX_VAL: SAT=0 -> 0; SAT=1 -> hold MAX_VAL and RUN <= 0.
  - Down, VAL>0: VAL-1.
  - Down, VAL==0: SAT=0 -> MAX_VAL; SAT=1 -> hold 0 and RUN <= 0.
  - TICK <= 1 on every tick.
  - DONE <= 1 only on a terminal tick, i.e. when the tick started at MAX_VAL (up) or 0 (down).
- Stop edge coinciding with a tick: the tick update is applied, then the state goes IDLE.
- Lap:
  - BTN_LAP rise in RUN: LAP_VAL <= pre-update VAL, LAP_VLD <= 1.
  - BTN_LAP rise in IDLE: LAP_VLD <= 0; LAP_VAL is unchanged.
  - When a lap and a tick share an edge, LAP_VAL gets the old VAL.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
Settings for scenarios 1-6 unless stated: TICK_DIV=4, VAL_W=4, MAX_VAL=9, SAT=0.

1. Hold BTN_SS=1 through reset, keep it high 10 cycles after RST_N rises -> RUN=0, VAL=0, no TICK; release and press again -> RUN=1 one cycle after the edge.
2. Start, run 9 cycles, stop, wait 20 cycles, restart:
   - TICK at cycles 4 and 8; VAL=2 when stopped.
   - After restart, the next tick comes 3 cycles later (prescaler resumed at 1); VAL=3.
3. Up-count from 8 with SAT=0 -> VAL 8, 9, 0 with DONE=1 on the 9->0 cycle only; repeat with SAT=1 -> VAL stays 9, DONE pulses once, RUN falls the same cycle.
4. DOWN=1, LOAD with LOAD_VAL=3 in IDLE, start, SAT=1 -> VAL 3, 2, 1, 0, then DONE on the next tick and RUN=0, VAL=0; LOAD_VAL=12 -> VAL=9 (clamped).
5. Lap rise while VAL=5 and a tick on the same edge -> LAP_VAL=5, LAP_VLD=1, VAL=6; lap rise after stop -> LAP_VLD=0, LAP_VAL=5.
6. Priority cases:
   - LOAD=1 while RUN -> VAL unaffected.
   - CLR asserted on the same edge as a BTN_SS rise and a tick -> VAL=0, RUN=0, TICK=0 next cycle.
   - RST_N low mid-run -> all outputs 0 on the next edge.
